// File: rtl/instruction_fetcher_pkg.sv
// Shared front-end definitions: RV32I opcodes, immediate extraction
// and the instruction-queue entry layout.
package instruction_fetcher_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int IQ_ENTRY_W = 96;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } iq_entry_t;

  typedef enum logic [1:0] {
    PRED_SEQ,
    PRED_JAL,
    PRED_BR
  } pred_kind_t;

  function automatic logic [31:0] imm_j(
    input logic [31:0] inst
  );
    return {{11{inst[31]}}, inst[31],
            inst[19:12], inst[20],
            inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(
    input logic [31:0] inst
  );
    return {{19{inst[31]}}, inst[31],
            inst[7], inst[30:25],
            inst[11:8], 1'b0};
  endfunction

  // Static rule: JAL and backward branches
  // are taken; JALR targets are unknown here.
  function automatic pred_kind_t pred_kind(
    input logic [31:0] inst
  );
    pred_kind_t k;
    k = PRED_SEQ;
    case (inst[6:0])
      OP_JAL:    k = PRED_JAL;
      OP_BRANCH: k = inst[31] ? PRED_BR
                              : PRED_SEQ;
      OP_JALR:   k = PRED_SEQ;
      default:   k = PRED_SEQ;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/instruction_fetcher_queue.sv
// In-order instruction queue between fetch
// and decode, with flush and full/empty.
module instruction_queue #(
  parameter int DEPTH_LOG = 3,
  parameter int WIDTH     = 96
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT =
    (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && do_push) mem[wr_ptr] <= din;
  end

  // Empty reads as zero so the decoder view is
  // defined straight out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: PC register, stale-response
// filter, static predictor and decode queue.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          IQ_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [31:0] req_pc,
  input  logic [31:0] icache_inst,
  input  logic        icache_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc
);

  logic        stale;
  logic        accept;
  logic        do_pop;
  logic        iq_full;
  logic        iq_empty;
  logic [31:0] pred_pc;
  pred_kind_t  kind;
  iq_entry_t   push_ent;
  iq_entry_t   head_ent;

  assign kind = pred_kind(icache_inst);

  always_comb begin
    pred_pc = req_pc + 32'd4;
    unique case (kind)
      PRED_JAL: pred_pc = req_pc + imm_j(icache_inst);
      PRED_BR:  pred_pc = req_pc + imm_b(icache_inst);
      default:  pred_pc = req_pc + 32'd4;
    endcase
  end

  // A response is only trusted if req_pc was
  // steady for the whole previous cycle.
  assign accept = icache_valid && !stale &&
                  !iq_full && !redirect_en;
  assign do_pop = dec_ready && !iq_empty &&
                  !redirect_en;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      req_pc <= RESET_PC;
      stale  <= 1'b1;
    end else if (redirect_en) begin
      req_pc <= redirect_pc;
      stale  <= 1'b1;
    end else if (accept) begin
      req_pc <= pred_pc;
      stale  <= 1'b1;
    end else begin
      stale  <= 1'b0;
    end
  end

  assign push_ent = '{
    inst:    icache_inst,
    pc:      req_pc,
    pred_pc: pred_pc
  };

  logic [IQ_ENTRY_W-1:0] head_bits;

  instruction_queue #(
    .DEPTH_LOG (IQ_DEPTH_LOG),
    .WIDTH     (IQ_ENTRY_W)
  ) u_iq (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (redirect_en),
    .push   (accept),
    .din    (push_ent),
    .pop    (do_pop),
    .dout   (head_bits),
    .full   (iq_full),
    .empty  (iq_empty)
  );

  assign head_ent    = head_bits;
  assign dec_inst    = head_ent.inst;
  assign dec_pc      = head_ent.pc;
  assign dec_pred_pc = head_ent.pred_pc;
  assign dec_valid   = !iq_empty;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: cache model,
// scoreboard, predictor table, corner sequences.
module tb_instruction_fetcher;

  localparam logic [31:0] ADDI = 32'h00100093;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] req_pc;
  logic [31:0] icache_inst = '0;
  logic        icache_valid = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  always #5 clk_in = ~clk_in;

  instruction_fetcher #(
    .RESET_PC     (32'h0),
    .IQ_DEPTH_LOG (3)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_pc       (req_pc),
    .icache_inst  (icache_inst),
    .icache_valid (icache_valid),
    .dec_inst     (dec_inst),
    .dec_pc       (dec_pc),
    .dec_pred_pc  (dec_pred_pc),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc)
  );

  logic [31:0] imem [logic [31:0]];
  bit hit_en;

  function automatic logic [31:0] fetch_word(
    input logic [31:0] a
  );
    return imem.exists(a) ? imem[a] : ADDI;
  endfunction

  // Registered cache: answers last cycle's req_pc.
  always @(posedge clk_in) begin
    icache_valid <= hit_en;
    icache_inst  <= fetch_word(req_pc);
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_stale;
  int          n_checks;
  int          n_errors;
  int          push_cnt;
  logic [31:0] pc_log[$];
  ent_t        pop_log[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_pred(
    input logic [31:0] i,
    input logic [31:0] pc
  );
    logic [20:0] jo;
    logic [12:0] bo;
    jo = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    bo = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    if (i[6:0] == 7'h6F)
      return pc + {{11{jo[20]}}, jo};
    if (i[6:0] == 7'h63 && i[31])
      return pc + {{19{bo[12]}}, bo};
    return pc + 32'd4;
  endfunction

  task automatic step();
    bit          acc;
    bit          pop;
    bit          r_rst;
    bit          r_red;
    logic [31:0] r_rpc;
    logic [31:0] r_inst;
    logic [31:0] prev;
    ent_t        e;
    acc    = 1'b0;
    pop    = 1'b0;
    r_rst  = rst_in;
    r_red  = redirect_en;
    r_rpc  = redirect_pc;
    r_inst = icache_inst;
    prev   = req_pc;
    if (r_rst) begin
      chk("req_pc", req_pc, m_pc);
      chk("dec_valid", dec_valid, 32'(m_q.size() != 0));
      pop = dec_ready && m_q.size() != 0 && !r_red;
      acc = icache_valid && !m_stale &&
            m_q.size() < 8 && !r_red;
      if (pop) begin
        chk("sb_inst", dec_inst, m_q[0].inst);
        chk("sb_pc", dec_pc, m_q[0].pc);
        chk("sb_pred", dec_pred_pc, m_q[0].pred);
        e.inst = dec_inst;
        e.pc   = dec_pc;
        e.pred = dec_pred_pc;
        pop_log.push_back(e);
      end
    end
    @(posedge clk_in);
    if (!r_rst) begin
      m_q.delete();
      m_pc    = 32'h0;
      m_stale = 1'b1;
    end else if (r_red) begin
      m_q.delete();
      m_pc    = r_rpc;
      m_stale = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        e.inst = r_inst;
        e.pc   = m_pc;
        e.pred = ref_pred(r_inst, m_pc);
        m_q.push_back(e);
        m_pc    = e.pred;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
    end
    #1;
    if (r_rst && !r_red && req_pc !== prev)
      push_cnt++;
    if (pc_log.size() == 0 || pc_log[$] !== req_pc)
      pc_log.push_back(req_pc);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exp_pred;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] exp_pc[6];
    logic [31:0] exp_pd[6];
    logic [31:0] exp_seq[7];
    logic [31:0] base;
    int          cnt0;
    int          guard;

    vecs[0] = '{32'h00000000, 32'h00100093, 32'h00000004};
    vecs[1] = '{32'h00000010, 32'h0100006F, 32'h00000020};
    vecs[2] = '{32'h00000020, 32'hFE000CE3, 32'h00000018};
    vecs[3] = '{32'h00000040, 32'h00000463, 32'h00000044};
    vecs[4] = '{32'h00000050, 32'h000100E7, 32'h00000054};
    vecs[5] = '{32'h00000000, 32'hFFDFF06F, 32'hFFFFFFFC};
    vecs[6] = '{32'hFFFFFFFC, 32'h0080006F, 32'h00000004};
    vecs[7] = '{32'h00000060, 32'hFE001CE3, 32'h00000058};
    vecs[8] = '{32'h00000070, 32'h80000063, 32'hFFFFF070};

    n_checks    = 0;
    n_errors    = 0;
    push_cnt    = 0;
    rst_in      = 1'b0;
    dec_ready   = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    hit_en      = 1'b1;
    m_pc        = '0;
    m_stale     = 1'b1;

    // Tests 1-2: sequential, JAL, backward BEQ
    imem[32'h10] = 32'h0100006F;
    imem[32'h20] = 32'hFE000CE3;
    step();
    step();
    chk("rst_req_pc", req_pc, 32'h0);
    chk("rst_dec_valid", dec_valid, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    rst_in = 1'b1;
    pc_log.delete();
    pop_log.delete();
    pc_log.push_back(req_pc);
    repeat (16) step();
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC,
                32'h10, 32'h20, 32'h18};
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC,
                32'h10, 32'h20};
    exp_pd  = '{32'h4, 32'h8, 32'hC, 32'h10,
                32'h20, 32'h18};
    chk("t1_pc_log_len_ok",
        32'(pc_log.size() >= 7), 32'h1);
    chk("t1_pop_log_len_ok",
        32'(pop_log.size() >= 6), 32'h1);
    for (int i = 0; i < 7; i++)
      if (i < pc_log.size())
        chk("t12_req_pc_seq", pc_log[i], exp_seq[i]);
    for (int i = 0; i < 6; i++)
      if (i < pop_log.size()) begin
        chk("t12_pop_pc", pop_log[i].pc, exp_pc[i]);
        chk("t12_pop_pred", pop_log[i].pred, exp_pd[i]);
      end

    // Test 3: back-pressure fills the queue
    imem.delete();
    dec_ready = 1'b0;
    rst_in    = 1'b0;
    step();
    rst_in   = 1'b1;
    push_cnt = 0;
    repeat (20) step();
    chk("t3_pushes_full", push_cnt, 8);
    chk("t3_req_pc_frozen", req_pc, 32'h20);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    repeat (10) step();
    chk("t3_one_more_push", push_cnt, 9);
    chk("t3_req_pc_after", req_pc, 32'h24);
    chk("t3_head_pc", dec_pc, 32'h4);

    // Test 4: redirect with pop and accept pending
    rst_in = 1'b0;
    step();
    rst_in   = 1'b1;
    push_cnt = 0;
    guard    = 0;
    while (push_cnt < 5 && guard < 30) begin
      step();
      guard++;
    end
    chk("t4_fill5", push_cnt, 5);
    step();
    chk("t4_pre_valid", dec_valid, 32'h1);
    imem[32'h100] = 32'h00200113;
    dec_ready   = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_en = 1'b0;
    chk("t4_flush_valid", dec_valid, 32'h0);
    chk("t4_req_pc", req_pc, 32'h100);
    step();
    chk("t4_stale_req_pc", req_pc, 32'h100);
    chk("t4_stale_valid", dec_valid, 32'h0);
    step();
    chk("t4_fetch_req_pc", req_pc, 32'h104);
    chk("t4_fetch_valid", dec_valid, 32'h1);
    chk("t4_fetch_pc", dec_pc, 32'h100);
    chk("t4_fetch_inst", dec_inst, 32'h00200113);
    chk("t4_fetch_pred", dec_pred_pc, 32'h104);

    // Test 5: 20-cycle miss, then resume
    hit_en = 1'b0;
    step();
    base = m_pc;
    cnt0 = push_cnt;
    repeat (20) step();
    chk("t5_miss_req_pc", req_pc, base);
    chk("t5_miss_pushes", push_cnt, cnt0);
    chk("t5_miss_valid", dec_valid, 32'h0);
    hit_en = 1'b1;
    repeat (6) step();
    chk("t5_resume_req_pc", req_pc, base + 32'd12);
    chk("t5_resume_pushes", push_cnt, cnt0 + 3);

    // Test 6: reset with a half-full queue
    dec_ready = 1'b0;
    cnt0  = push_cnt;
    guard = 0;
    while (push_cnt < cnt0 + 4 && guard < 20) begin
      step();
      guard++;
    end
    chk("t6_fill", push_cnt, cnt0 + 4);
    chk("t6_pre_valid", dec_valid, 32'h1);
    rst_in = 1'b0;
    step();
    chk("t6_req_pc", req_pc, 32'h0);
    chk("t6_dec_valid", dec_valid, 32'h0);
    chk("t6_dec_inst", dec_inst, 32'h0);
    chk("t6_dec_pc", dec_pc, 32'h0);
    chk("t6_dec_pred", dec_pred_pc, 32'h0);
    rst_in = 1'b1;
    step();

    // Predictor table, one fetch per redirect
    for (int v = 0; v < 9; v++) begin
      imem[vecs[v].pc] = vecs[v].inst;
      redirect_en = 1'b1;
      redirect_pc = vecs[v].pc;
      step();
      redirect_en = 1'b0;
      guard = 0;
      while (!dec_valid && guard < 6) begin
        step();
        guard++;
      end
      chk("vec_timeout", 32'(dec_valid), 32'h1);
      chk("vec_pc", dec_pc, vecs[v].pc);
      chk("vec_inst", dec_inst, vecs[v].inst);
      chk("vec_pred", dec_pred_pc, vecs[v].exp_pred);
      chk("vec_req_pc", req_pc, vecs[v].exp_pred);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
